// File: rtl/mips_retire_trace.sv
// Retire-trace FIFO behind the mips core. It captures pc_nxt/result pairs with a
// sequence tag, presents the head entry first-word fall-through, and counts rejected captures.
module mips_retire_trace #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_en,
    input  logic [31:0]              pc_nxt,
    input  logic [31:0]              result,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_result,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [SEQ_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      res;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           entry_d;
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] drop_q, drop_d;
    logic             pop, push, drop;

    assign out_valid  = (occ_q != '0);
    assign empty      = (occ_q == '0);
    assign full       = (occ_q == CW'(DEPTH));
    assign count      = occ_q;
    assign drop_cnt   = drop_q;
    assign out_pc     = mem_q[rp_q].pc;
    assign out_result = mem_q[rp_q].res;
    assign out_seq    = mem_q[rp_q].seq;

    always_comb begin
        // A pop frees a slot in the same cycle, so a full FIFO still accepts when drained.
        pop     = out_valid && out_ready && !flush;
        push    = cap_en && !flush && (!full || pop);
        drop    = cap_en && !flush && full && !pop;
        entry_d = '{pc: pc_nxt, res: result, seq: seq_q};
        wp_d    = wp_q;
        rp_d    = rp_q;
        occ_d   = occ_q;
        seq_d   = seq_q + SEQ_W'(cap_en);
        drop_d  = drop_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            occ_d = '0;
        end else begin
            if (push) wp_d = wp_q + AW'(1);
            if (pop)  rp_d = rp_q + AW'(1);
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
        if (drop && drop_q != {SEQ_W{1'b1}}) drop_d = drop_q + SEQ_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q   <= '0;
            rp_q   <= '0;
            occ_q  <= '0;
            seq_q  <= '0;
            drop_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            occ_q  <= occ_d;
            seq_q  <= seq_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wp_q] <= entry_d;
    end

endmodule

// File: tb/tb_mips_retire_trace.sv
// Randomized scoreboard bench for mips_retire_trace: an abstract queue model predicts
// every accepted capture, and a negedge monitor checks the head entry and status outputs.
module tb_mips_retire_trace;

    localparam int DEPTH = 8;
    localparam int SEQ_W = 4;
    localparam int SEQ_MAX = (1 << SEQ_W) - 1;

    logic              clk, reset, cap_en, flush, out_ready;
    logic [31:0]       pc_nxt, result;
    logic              out_valid, full, empty;
    logic [31:0]       out_pc, out_result;
    logic [SEQ_W-1:0]  out_seq, drop_cnt;
    logic [$clog2(DEPTH):0] count;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        int          seq;
    } ent_t;

    ent_t exp_q[$];
    int   m_occ = 0;
    int   m_seq = 0;
    int   m_drops = 0;

    mips_retire_trace #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .reset(reset), .cap_en(cap_en), .pc_nxt(pc_nxt), .result(result),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_result(out_result), .out_seq(out_seq), .count(count), .full(full),
        .empty(empty), .drop_cnt(drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: occupancy, tag and drop rules applied to an abstract queue.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_occ = 0; m_seq = 0; m_drops = 0;
                exp_q.delete();
            end else begin
                automatic bit do_pop = (m_occ > 0) && out_ready && !flush;
                if (flush) begin
                    m_occ = 0;
                    exp_q.delete();
                end else begin
                    if (cap_en) begin
                        if (m_occ < DEPTH || do_pop) begin
                            exp_q.push_back('{pc: pc_nxt, res: result, seq: m_seq});
                            m_occ++;
                        end else if (m_drops < SEQ_MAX) begin
                            m_drops++;
                        end
                    end
                    if (do_pop) m_occ--;
                end
                if (cap_en) m_seq = (m_seq + 1) % (SEQ_MAX + 1);
            end
        end
    end

    // Monitor: head entry and status compared mid-cycle; handshakes consume expectations.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", longint'(out_valid), longint'(m_occ > 0));
            chk("count", longint'(count), longint'(m_occ));
            chk("full", longint'(full), longint'(m_occ == DEPTH));
            chk("empty", longint'(empty), longint'(m_occ == 0));
            chk("drop_cnt", longint'(drop_cnt), longint'(m_drops));
            if (out_valid && exp_q.size() > 0) begin
                chk("out_pc", longint'(out_pc), longint'(exp_q[0].pc));
                chk("out_result", longint'(out_result), longint'(exp_q[0].res));
                chk("out_seq", longint'(out_seq), longint'(exp_q[0].seq));
                if (out_ready && !flush && !reset) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input bit cap, input logic [31:0] pc, input logic [31:0] res,
                       input bit fl, input bit rdy, input bit rst);
        cap_en = cap; pc_nxt = pc; result = res; flush = fl; out_ready = rdy; reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cap_en = 0; pc_nxt = 0; result = 0; flush = 0; out_ready = 0; reset = 1;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_empty", longint'(empty), 1);
        chk("rst_drop", longint'(drop_cnt), 0);

        // Basic capture: visible one cycle after the edge.
        cyc(1, 32'h4, 32'h0A, 0, 0, 0);
        chk("basic_valid", longint'(out_valid), 1);
        chk("basic_pc", longint'(out_pc), 32'h4);
        chk("basic_res", longint'(out_result), 32'h0A);
        chk("basic_seq", longint'(out_seq), 0);
        chk("basic_count", longint'(count), 1);

        // Fill past capacity, then drain in order.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 32'(4 * i), 32'(i + 100), 0, 0, 0);
        chk("fill_full", longint'(full), 1);
        chk("fill_count", longint'(count), DEPTH);
        chk("fill_drop", longint'(drop_cnt), 2);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_seq", longint'(out_seq), i);
            chk("drain_pc", longint'(out_pc), 4 * i);
            cyc(0, 0, 0, 0, 1, 0);
        end
        chk("drain_empty", longint'(empty), 1);

        // Full with simultaneous push/pop: no drops, count pinned at DEPTH.
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h200 + 32'(i), $urandom, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 32'h300 + 32'(i), $urandom, 0, 1, 0);
        chk("pp_count", longint'(count), DEPTH);
        chk("pp_drop", longint'(drop_cnt), 2);

        // Flush with concurrent capture: tag consumed, not a drop.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, $urandom, $urandom, 0, 0, 0);
        cyc(1, $urandom, $urandom, 1, 1, 0);
        chk("flush_empty", longint'(empty), 1);
        chk("flush_drop", longint'(drop_cnt), 0);
        cyc(1, 32'h44, 32'h55, 0, 0, 0);
        chk("flush_seq", longint'(out_seq), 4);

        // Tag wrap with continuous drain.
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1, $urandom, $urandom, 0, 1, 0);

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < DEPTH + 20; i++) cyc(1, $urandom, $urandom, 0, 0, 0);
        chk("sat_drop", longint'(drop_cnt), SEQ_MAX);

        // Mid-stream reset.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, $urandom, $urandom, 0, 0, 0);
        chk("mid_valid_pre", longint'(out_valid), 1);
        cyc(1, $urandom, $urandom, 1, 1, 1);
        chk("mid_valid", longint'(out_valid), 0);
        chk("mid_count", longint'(count), 0);
        cyc(1, 32'h88, 32'h99, 0, 0, 0);
        chk("mid_seq", longint'(out_seq), 0);

        // Random traffic with varying consumer pressure.
        for (int seg = 0; seg < 6; seg++) begin
            automatic int rdy_pct = (seg % 3 == 0) ? 20 : (seg % 3 == 1) ? 60 : 95;
            for (int i = 0; i < 100; i++) begin
                cyc($urandom_range(0, 3) != 0, $urandom, $urandom,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 99) < rdy_pct,
                    $urandom_range(0, 149) == 0);
            end
        end
        cyc(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
